// File: rtl/echo_delay_ctrl.sv
// Echo delay controller: writes each codec sample into a shared single-port RAM and reads back the
// sample delay_q positions earlier. Define ECHO_CTRL_RELOAD_EN to resample delay_len on every sample.
module echo_delay_ctrl #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              new_sample_ready,
    input  logic [DATA_W-1:0] sample_in,
    input  logic [ADDR_W-1:0] delay_len,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [DATA_W-1:0] echo_sample,
    output logic              echo_valid,
    output logic              busy,
    output logic              overrun,
    output logic [1:0]        o_dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WRITE   = 2'd1,
        ST_READ    = 2'd2,
        ST_CAPTURE = 2'd3
    } state_t;

    state_t              r_state, w_state;
    logic                r_nsr_q;
    logic [ADDR_W-1:0]   r_wr_ptr, w_wr_ptr;
    logic [ADDR_W-1:0]   r_fill_cnt, w_fill_cnt;
    logic [ADDR_W-1:0]   r_delay_q, w_delay_q;
    logic [DATA_W-1:0]   r_hold, w_hold;
    logic [ADDR_W-1:0]   r_ram_addr, w_ram_addr;
    logic                r_ram_we, w_ram_we;
    logic [DATA_W-1:0]   r_echo_sample, w_echo_sample;
    logic                r_echo_valid, w_echo_valid;
    logic                r_overrun, w_overrun;
    logic                w_strobe;
`ifndef ECHO_CTRL_RELOAD_EN
    logic                r_delay_loaded, w_delay_loaded;
`endif

    assign w_strobe = new_sample_ready & ~r_nsr_q;

    // Outputs are registered one step ahead of the state so each state's RAM
    // signals are stable for its whole cycle. echo_valid is a one-cycle strobe
    // with no backpressure: the consumer must take echo_sample while it is high.
    always_comb begin
        w_state       = r_state;
        w_wr_ptr      = r_wr_ptr;
        w_fill_cnt    = r_fill_cnt;
        w_delay_q     = r_delay_q;
        w_hold        = r_hold;
        w_ram_addr    = r_ram_addr;
        w_ram_we      = 1'b0;
        w_echo_sample = r_echo_sample;
        w_echo_valid  = 1'b0;
        w_overrun     = r_overrun;
`ifndef ECHO_CTRL_RELOAD_EN
        w_delay_loaded = r_delay_loaded;
`endif
        if (w_strobe && (r_state != ST_IDLE)) begin
            w_overrun = 1'b1;
        end
        case (r_state)
            ST_IDLE: begin
                if (w_strobe) begin
                    w_state    = ST_WRITE;
                    w_hold     = sample_in;
                    w_ram_we   = 1'b1;
                    w_ram_addr = r_wr_ptr;
`ifdef ECHO_CTRL_RELOAD_EN
                    w_delay_q = delay_len;
                    if (delay_len != r_delay_q) begin
                        w_fill_cnt = '0;
                    end
`else
                    if (!r_delay_loaded) begin
                        w_delay_q      = delay_len;
                        w_delay_loaded = 1'b1;
                    end
`endif
                end
            end
            ST_WRITE: begin
                w_wr_ptr = r_wr_ptr + ADDR_W'(1);
                if (r_fill_cnt != {ADDR_W{1'b1}}) begin
                    w_fill_cnt = r_fill_cnt + ADDR_W'(1);
                end
                // Only read once enough history exists for the requested delay.
                if (r_fill_cnt >= r_delay_q) begin
                    w_state    = ST_READ;
                    w_ram_addr = r_wr_ptr - r_delay_q;
                end else begin
                    w_state = ST_IDLE;
                end
            end
            ST_READ: begin
                w_state = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                w_echo_sample = ram_rdata;
                w_echo_valid  = 1'b1;
                w_state       = ST_IDLE;
            end
            default: begin
                w_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_nsr_q       <= 1'b0;
            r_wr_ptr      <= '0;
            r_fill_cnt    <= '0;
            r_delay_q     <= '0;
            r_hold        <= '0;
            r_ram_addr    <= '0;
            r_ram_we      <= 1'b0;
            r_echo_sample <= '0;
            r_echo_valid  <= 1'b0;
            r_overrun     <= 1'b0;
`ifndef ECHO_CTRL_RELOAD_EN
            r_delay_loaded <= 1'b0;
`endif
        end else begin
            r_state       <= w_state;
            r_nsr_q       <= new_sample_ready;
            r_wr_ptr      <= w_wr_ptr;
            r_fill_cnt    <= w_fill_cnt;
            r_delay_q     <= w_delay_q;
            r_hold        <= w_hold;
            r_ram_addr    <= w_ram_addr;
            r_ram_we      <= w_ram_we;
            r_echo_sample <= w_echo_sample;
            r_echo_valid  <= w_echo_valid;
            r_overrun     <= w_overrun;
`ifndef ECHO_CTRL_RELOAD_EN
            r_delay_loaded <= w_delay_loaded;
`endif
        end
    end

    assign ram_addr    = r_ram_addr;
    assign ram_we      = r_ram_we;
    assign ram_wdata   = r_hold;
    assign echo_sample = r_echo_sample;
    assign echo_valid  = r_echo_valid;
    assign busy        = (r_state != ST_IDLE);
    assign overrun     = r_overrun;
    assign o_dbg_state = r_state;

endmodule
